data_mem_lsu: RTL and testbench
===============================

Name: data_mem_lsu

Overview:
Load/store unit between the MEM stage and the data-memory bus. It converts the MEM-stage access (address, write data, fun3 op) into a word-aligned bus transaction with byte strobes. It stalls the pipeline until the bus acknowledges. It returns aligned, sign/zero-extended load data that is held stable through the WB cycle.

Parameters:
TIMEOUT_CYCLES, 255, max cycles waiting for gnt+rvalid before bus_err; counter width is $clog2(TIMEOUT_CYCLES+1)

Ports:
clk  in  1  core clock
reset  in  1  reset; one clock, reset is asynchronous and active-high
mem_addr_mem  in  32  byte address (ALU result)
mem_wdata_mem  in  32  store data (post-forwarding)
mem_op_mem  in  3  fun3 access type
mem_write_mem  in  1  store in MEM stage
mem_to_reg_mem  in  1  load in MEM stage
advance  in  1  MEM->WB register enable this cycle (mem_wb_reg_en)
lsu_stall  out  1  freeze PC/IF/ID/EXE/MEM registers
mem_rdata_mem  out  32  formatted load data, valid in WB cycle
misalign_err  out  1  one-cycle pulse: misaligned or illegal op
bus_err  out  1  one-cycle pulse: timeout
bus_req  out  1  request valid
bus_we  out  1  write request
bus_addr  out  32  {mem_addr_mem[31:2],2'b00}
bus_wdata  out  32  lane-replicated store data
bus_wstrb  out  4  byte enables (0 for reads)
bus_gnt  in  1  request accepted this cycle
bus_rvalid  in  1  response/ack; one per accepted request
bus_rdata  in  32  read word

Behaviour:
- access = mem_write_mem | mem_to_reg_mem; both high at once is illegal and treated as a store.
- Reset: state IDLE, rdata_q=0, timeout counter=0, all outputs 0.
- States: IDLE, WAIT_GNT, WAIT_RESP, DONE.
- IDLE, access and legal:
  - bus_req=1 and lsu_stall=1, both combinational.
  - gnt -> WAIT_RESP; no gnt -> WAIT_GNT.
- IDLE, access but misaligned/illegal:
  - No bus_req; lsu_stall=1 for this cycle; misalign_err=1 on the IDLE->DONE transition.
  - rdata_q<=0, state DONE.
- WAIT_GNT: bus_req=1, lsu_stall=1; gnt -> WAIT_RESP.
- WAIT_RESP: bus_req=0, lsu_stall=1.
  - rvalid -> DONE; loads capture formatted bus_rdata into rdata_q; stores discard it.
  - rvalid in the same cycle as gnt is legal only from WAIT_RESP; a same-cycle gnt+rvalid in IDLE is ignored as a response.
- DONE: lsu_stall=0; stay until advance=1, then IDLE. No re-issue while the same instruction sits in MEM.
- Timeout: counter clears on entering WAIT_GNT and counts in WAIT_GNT/WAIT_RESP. At TIMEOUT_CYCLES: bus_err pulse, rdata_q<=0, go DONE. A late rvalid is then dropped.
- Inputs are held stable by the pipeline while lsu_stall=1. bus_addr/wdata/wstrb/we are driven from the inputs and remain stable while bus_req=1.
- mem_rdata_mem = rdata_q; it changes only on load completion or error.
- Minimum latency: gnt in the IDLE cycle plus rvalid one cycle later gives 2 stall cycles, then DONE.
- Alignment, off=addr[1:0]:
  - LB/LBU/SB: any off.
  - LH/LHU/SH: off[0]=0.
  - LW/SW: off=0.
  - fun3 011/110/111: illegal for loads and stores; fun3 100/101 illegal for stores.
- Stores:
  - SB: wdata={4{b}}, wstrb=4'b0001<<off.
  - SH: wdata={2{h}}, wstrb=4'b0011<<off.
  - SW: wstrb=4'hF.
- Loads:
  - Byte = bus_rdata[8*off+:8], halfword = bus_rdata[16*off[1]+:16].
  - LB/LH sign-extend; LBU/LHU zero-extend.

Decomposition:
- lsu_pkg: lsu_state_t enum; fun3 constants (LSU_B=3'b000, LSU_H=3'b001, LSU_W=3'b010, LSU_BU=3'b100, LSU_HU=3'b101); lsu_legal() function.
- One combinational sub-module lsu_load_align(op, off, word -> data) for load extraction/extension, reused by the bench model.

Test Plan:
- LW addr 0x100, gnt same cycle, rvalid next cycle with rdata 0xDEADBEEF -> stall 2 cycles; mem_rdata_mem=0xDEADBEEF in WB; bus_addr=0x100, wstrb=0.
- LB addr 0x203, rdata 0x80FF_FF7F -> 0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x202 -> 0x000080FF.
- SH addr 0x306, wdata 0x1234ABCD -> bus_wdata 0xABCDABCD, wstrb 4'b1100, bus_addr 0x304; no mem_rdata change.
- LW addr 0x102 -> no bus_req, misalign_err one pulse, rdata 0, lsu_stall exactly 1 cycle.
- gnt withheld 3 cycles, rvalid 4 cycles later, advance=0 two extra cycles in DONE -> single request; bus_req held with stable addr; no re-issue; IDLE after advance.
- TIMEOUT_CYCLES=8, never rvalid -> bus_err after 8 wait cycles, rdata 0. Assert reset mid-WAIT_RESP -> immediate IDLE, req=0, stall=0.

Source files
------------

// File: rtl/lsu_pkg.sv
// Load/store unit shared definitions.
// Contents:
//   lsu_state_t      - bus handshake state encoding
//   LSU_* constants  - fun3 access-type encodings
//   lsu_legal()      - op/alignment legality check
//   lsu_store_strb() - byte strobes for a store
//   lsu_store_data() - lane-replicated store data
package lsu_pkg;

    typedef enum logic [1:0] {
        LSU_IDLE      = 2'd0,
        LSU_WAIT_GNT  = 2'd1,
        LSU_WAIT_RESP = 2'd2,
        LSU_DONE      = 2'd3
    } lsu_state_t;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    // Unsigned variants only exist for loads; 011/110/111 are never legal.
    function automatic logic lsu_legal(input logic [2:0] op,
                                       input logic [1:0] off,
                                       input logic       is_store);
        logic ok;
        case (op)
            LSU_B:   ok = 1'b1;
            LSU_H:   ok = ~off[0];
            LSU_W:   ok = (off == 2'b00);
            LSU_BU:  ok = ~is_store;
            LSU_HU:  ok = ~is_store & ~off[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] lsu_store_strb(input logic [2:0] op,
                                                  input logic [1:0] off);
        logic [3:0] strb;
        case (op[1:0])
            2'b00:   strb = 4'b0001 << off;
            2'b01:   strb = 4'b0011 << off;
            2'b10:   strb = 4'b1111;
            default: strb = 4'b0000;
        endcase
        return strb;
    endfunction

    // Replicating the narrow datum on every lane lets the bus pick it
    // up purely by strobe, without a data shifter.
    function automatic logic [31:0] lsu_store_data(input logic [2:0]  op,
                                                   input logic [31:0] wdata);
        logic [31:0] data;
        case (op[1:0])
            2'b00:   data = {4{wdata[7:0]}};
            2'b01:   data = {2{wdata[15:0]}};
            default: data = wdata;
        endcase
        return data;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data extraction and extension.
// Ports:
//   op   in  3   fun3 load type
//   off  in  2   byte offset within the word
//   word in  32  raw bus read word
//   data out 32  selected, sign/zero-extended load value
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  off,
    input  logic [31:0] word,
    output logic [31:0] data
);

    logic [31:0] shifted_s;
    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane select, then extend according to the access type
    always_comb begin
        shifted_s = word >> {off, 3'b000};
        byte_s    = shifted_s[7:0];
        half_s    = off[1] ? word[31:16] : word[15:0];
        case (op)
            LSU_B:   data = {{24{byte_s[7]}}, byte_s};
            LSU_BU:  data = {24'h000000, byte_s};
            LSU_H:   data = {{16{half_s[15]}}, half_s};
            LSU_HU:  data = {16'h0000, half_s};
            LSU_W:   data = word;
            default: data = 32'h00000000;
        endcase
    end

endmodule

// File: rtl/data_mem_lsu.sv
// Load/store unit between the MEM stage and the data-memory bus.
// Issues one word-aligned bus transaction per MEM-stage access, stalls the
// pipeline until it completes, and holds formatted load data for WB.
// Ports:
//   clk, reset                  clock, async active-high reset
//   mem_addr_mem/wdata/op       MEM-stage access (held while stalled)
//   mem_write_mem/mem_to_reg_mem store / load qualifiers
//   advance                     MEM->WB register enable
//   lsu_stall                   pipeline freeze (combinational)
//   mem_rdata_mem               formatted load data (registered)
//   misalign_err, bus_err       one-cycle registered error pulses, high in
//                               the first DONE cycle
//   bus_req/we/addr/wdata/wstrb request side (combinational, zero when idle)
//   bus_gnt/rvalid/rdata        bus response side
module data_mem_lsu
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_addr_mem,
    input  logic [31:0] mem_wdata_mem,
    input  logic [2:0]  mem_op_mem,
    input  logic        mem_write_mem,
    input  logic        mem_to_reg_mem,
    input  logic        advance,
    output logic        lsu_stall,
    output logic [31:0] mem_rdata_mem,
    output logic        misalign_err,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_t       state_r, state_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic [31:0]      rdata_r, rdata_nxt_s;
    logic             misalign_r, misalign_nxt_s;
    logic             bus_err_r, bus_err_nxt_s;
    logic             req_s, stall_s;

    logic        access_s, is_store_s, is_load_s, legal_s, timeout_s;
    logic [1:0]  off_s;
    logic [31:0] load_data_s;

    // A simultaneous load+store request is handled as a store
    assign access_s   = mem_write_mem | mem_to_reg_mem;
    assign is_store_s = mem_write_mem;
    assign is_load_s  = mem_to_reg_mem & ~mem_write_mem;
    assign off_s      = mem_addr_mem[1:0];
    assign legal_s    = lsu_legal(mem_op_mem, off_s, is_store_s);
    // cnt_r holds the wait cycles already spent; this is the last allowed one
    assign timeout_s  = (cnt_r == CNT_LAST);

    lsu_load_align u_align (
        .op   (mem_op_mem),
        .off  (off_s),
        .word (bus_rdata),
        .data (load_data_s)
    );

    // Handshake state register plus the registered result and error pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= LSU_IDLE;
            cnt_r      <= '0;
            rdata_r    <= 32'h00000000;
            misalign_r <= 1'b0;
            bus_err_r  <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            cnt_r      <= cnt_nxt_s;
            rdata_r    <= rdata_nxt_s;
            misalign_r <= misalign_nxt_s;
            bus_err_r  <= bus_err_nxt_s;
        end
    end

    // Next-state, timeout counter, result capture and request/stall decode
    always_comb begin
        state_nxt_s    = state_r;
        cnt_nxt_s      = cnt_r;
        rdata_nxt_s    = rdata_r;
        misalign_nxt_s = 1'b0;
        bus_err_nxt_s  = 1'b0;
        req_s          = 1'b0;
        stall_s        = 1'b0;
        case (state_r)
            LSU_IDLE: begin
                if (access_s && legal_s) begin
                    req_s     = 1'b1;
                    stall_s   = 1'b1;
                    cnt_nxt_s = '0;
                    // rvalid seen here cannot belong to this request
                    state_nxt_s = bus_gnt ? LSU_WAIT_RESP : LSU_WAIT_GNT;
                end else if (access_s) begin
                    stall_s        = 1'b1;
                    misalign_nxt_s = 1'b1;
                    rdata_nxt_s    = 32'h00000000;
                    state_nxt_s    = LSU_DONE;
                end else begin
                    state_nxt_s = LSU_IDLE;
                end
            end
            LSU_WAIT_GNT: begin
                req_s   = 1'b1;
                stall_s = 1'b1;
                if (timeout_s) begin
                    bus_err_nxt_s = 1'b1;
                    rdata_nxt_s   = 32'h00000000;
                    state_nxt_s   = LSU_DONE;
                end else if (bus_gnt) begin
                    cnt_nxt_s   = cnt_r + CNT_W'(1);
                    state_nxt_s = LSU_WAIT_RESP;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end
            LSU_WAIT_RESP: begin
                stall_s = 1'b1;
                // A response on the final allowed cycle still completes
                if (bus_rvalid) begin
                    if (is_load_s) begin
                        rdata_nxt_s = load_data_s;
                    end else begin
                        rdata_nxt_s = rdata_r;
                    end
                    state_nxt_s = LSU_DONE;
                end else if (timeout_s) begin
                    bus_err_nxt_s = 1'b1;
                    rdata_nxt_s   = 32'h00000000;
                    state_nxt_s   = LSU_DONE;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end
            LSU_DONE: begin
                // Wait here so the same instruction is never re-issued
                if (advance) begin
                    state_nxt_s = LSU_IDLE;
                end else begin
                    state_nxt_s = LSU_DONE;
                end
            end
            default: begin
                state_nxt_s = LSU_IDLE;
            end
        endcase
    end

    // Outputs; the combinational ones are forced low while reset is held
    assign bus_req       = req_s & ~reset;
    assign lsu_stall     = stall_s & ~reset;
    assign bus_we        = bus_req & is_store_s;
    assign bus_addr      = bus_req ? {mem_addr_mem[31:2], 2'b00} : 32'h00000000;
    assign bus_wdata     = bus_we ? lsu_store_data(mem_op_mem, mem_wdata_mem) : 32'h00000000;
    assign bus_wstrb     = bus_we ? lsu_store_strb(mem_op_mem, off_s) : 4'b0000;
    assign mem_rdata_mem = rdata_r;
    assign misalign_err  = misalign_r;
    assign bus_err       = bus_err_r;

endmodule

// File: tb/tb_data_mem_lsu.sv
module tb_data_mem_lsu;

    logic        clk;
    logic        reset;
    logic [31:0] mem_addr_mem;
    logic [31:0] mem_wdata_mem;
    logic [2:0]  mem_op_mem;
    logic        mem_write_mem;
    logic        mem_to_reg_mem;
    logic        advance;
    logic        lsu_stall;
    logic [31:0] mem_rdata_mem;
    logic        misalign_err;
    logic        bus_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    int total;
    int bad;
    logic [31:0] exp_rdata;

    data_mem_lsu #(.TIMEOUT_CYCLES(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_addr_mem   (mem_addr_mem),
        .mem_wdata_mem  (mem_wdata_mem),
        .mem_op_mem     (mem_op_mem),
        .mem_write_mem  (mem_write_mem),
        .mem_to_reg_mem (mem_to_reg_mem),
        .advance        (advance),
        .lsu_stall      (lsu_stall),
        .mem_rdata_mem  (mem_rdata_mem),
        .misalign_err   (misalign_err),
        .bus_err        (bus_err),
        .bus_req        (bus_req),
        .bus_we         (bus_we),
        .bus_addr       (bus_addr),
        .bus_wdata      (bus_wdata),
        .bus_wstrb      (bus_wstrb),
        .bus_gnt        (bus_gnt),
        .bus_rvalid     (bus_rvalid),
        .bus_rdata      (bus_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Access size in bytes from the fun3 low bits; 0 marks a reserved size
    function automatic int size_of(input logic [2:0] op);
        int n;
        case (op[1:0])
            2'b00:   n = 1;
            2'b01:   n = 2;
            2'b10:   n = 4;
            default: n = 0;
        endcase
        return n;
    endfunction

    function automatic logic model_legal(input logic [2:0] op, input logic [1:0] off, input logic st);
        int n;
        n = size_of(op);
        if (n == 0) return 1'b0;
        if (op[2] && (st || n == 4)) return 1'b0;
        return (int'(off) % n) == 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] op, input logic [1:0] off, input logic [31:0] w);
        logic [31:0] s;
        longint v;
        s = w >> (8 * int'(off));
        case (op)
            3'b000: begin v = longint'(s & 32'h000000FF); if (v >= 128) v -= 256; end
            3'b100: v = longint'(s & 32'h000000FF);
            3'b001: begin v = longint'(s & 32'h0000FFFF); if (v >= 32768) v -= 65536; end
            3'b101: v = longint'(s & 32'h0000FFFF);
            default: v = longint'(s);
        endcase
        return v[31:0];
    endfunction

    function automatic logic [3:0] model_strb(input logic [2:0] op, input logic [1:0] off);
        int n;
        int m;
        n = size_of(op);
        m = ((1 << n) - 1) << int'(off);
        return m[3:0];
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] op, input logic [31:0] wd);
        int n;
        logic [31:0] r;
        logic [31:0] b;
        n = size_of(op);
        r = 32'h00000000;
        for (int i = 0; i < 4; i++) begin
            b = (wd >> (8 * (i % n))) & 32'h000000FF;
            r = r | (b << (8 * i));
        end
        return r;
    endfunction

    // One MEM-stage access: gnt in cycle gdly (0 = first cycle), rvalid rdly
    // cycles after gnt, adv_dly extra DONE cycles before advance.
    task automatic run_access(input logic we, input logic ld, input logic [2:0] op,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input int gdly, input int rdly, input int adv_dly,
                              input logic spur, input logic [31:0] rword);
        logic st;
        logic is_ld;
        int rv_cyc;
        st = we;
        is_ld = ld & ~we;
        mem_write_mem  = we;
        mem_to_reg_mem = ld;
        mem_op_mem     = op;
        mem_addr_mem   = addr;
        mem_wdata_mem  = wd;
        advance        = 1'b0;
        if (!model_legal(op, addr[1:0], st)) begin
            bus_gnt = 1'b0;
            bus_rvalid = 1'b0;
            #1;
            check("mis_req", 32'(bus_req), 32'd0);
            check("mis_stall0", 32'(lsu_stall), 32'd1);
            step();
            exp_rdata = 32'h00000000;
            check("mis_pulse", 32'(misalign_err), 32'd1);
            check("mis_stall1", 32'(lsu_stall), 32'd0);
            check("mis_rdata", mem_rdata_mem, exp_rdata);
        end else begin
            rv_cyc = gdly + rdly;
            for (int c = 0; c <= rv_cyc; c++) begin
                bus_gnt    = (c == gdly);
                bus_rvalid = (c == rv_cyc) || (spur && gdly == 0 && c == 0);
                bus_rdata  = (c == rv_cyc) ? rword : $urandom;
                #1;
                check("stall", 32'(lsu_stall), 32'd1);
                if (c <= gdly) begin
                    check("req_on", 32'(bus_req), 32'd1);
                    check("addr", bus_addr, {addr[31:2], 2'b00});
                    check("we", 32'(bus_we), 32'(st));
                    check("wstrb", 32'(bus_wstrb), st ? 32'(model_strb(op, addr[1:0])) : 32'd0);
                    if (st) check("wdata", bus_wdata, model_wdata(op, wd));
                end else begin
                    check("req_off", 32'(bus_req), 32'd0);
                end
                step();
            end
            bus_gnt = 1'b0;
            bus_rvalid = 1'b0;
            if (is_ld) exp_rdata = model_load(op, addr[1:0], rword);
            check("done_stall", 32'(lsu_stall), 32'd0);
            check("done_req", 32'(bus_req), 32'd0);
            check("rdata", mem_rdata_mem, exp_rdata);
            check("done_berr", 32'(bus_err), 32'd0);
        end
        for (int k = 0; k < adv_dly; k++) begin
            step();
            check("hold_req", 32'(bus_req), 32'd0);
            check("hold_stall", 32'(lsu_stall), 32'd0);
            check("hold_mis", 32'(misalign_err), 32'd0);
            check("hold_rdata", mem_rdata_mem, exp_rdata);
        end
        advance = 1'b1;
        step();
        advance = 1'b0;
        mem_write_mem = 1'b0;
        mem_to_reg_mem = 1'b0;
        #1;
        check("idle_stall", 32'(lsu_stall), 32'd0);
        check("idle_req", 32'(bus_req), 32'd0);
        check("wb_rdata", mem_rdata_mem, exp_rdata);
        step();
    endtask

    initial begin
        int kind;
        logic [2:0] rop;
        total = 0;
        bad = 0;
        exp_rdata = 32'h00000000;
        reset = 1'b1;
        mem_addr_mem = 32'h0; mem_wdata_mem = 32'h0; mem_op_mem = 3'b000;
        mem_write_mem = 1'b0; mem_to_reg_mem = 1'b0; advance = 1'b0;
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
        #1;
        check("rst_req", 32'(bus_req), 32'd0);
        check("rst_stall", 32'(lsu_stall), 32'd0);
        check("rst_rdata", mem_rdata_mem, 32'h0);
        check("rst_errs", {30'd0, misalign_err, bus_err}, 32'd0);
        check("rst_strb", 32'(bus_wstrb), 32'd0);
        #11;
        reset = 1'b0;
        step();

        // Minimum-latency LW, byte/half loads, SH, misaligned LW
        run_access(1'b0, 1'b1, 3'b010, 32'h00000100, 32'h0, 0, 1, 0, 1'b0, 32'hDEADBEEF);
        run_access(1'b0, 1'b1, 3'b000, 32'h00000203, 32'h0, 0, 1, 0, 1'b0, 32'h80FFFF7F);
        run_access(1'b0, 1'b1, 3'b100, 32'h00000203, 32'h0, 0, 1, 0, 1'b0, 32'h80FFFF7F);
        run_access(1'b0, 1'b1, 3'b101, 32'h00000202, 32'h0, 0, 1, 0, 1'b0, 32'h80FFFF7F);
        run_access(1'b1, 1'b0, 3'b001, 32'h00000306, 32'h1234ABCD, 0, 1, 0, 1'b0, 32'h55555555);
        run_access(1'b0, 1'b1, 3'b010, 32'h00000102, 32'h0, 0, 1, 0, 1'b0, 32'h0);
        // Delayed grant, late response, lingering in DONE
        run_access(1'b0, 1'b1, 3'b010, 32'h00000440, 32'h0, 3, 4, 2, 1'b0, 32'hA5A5C3C3);
        // Same-cycle gnt+rvalid in the first cycle must not complete the load
        run_access(1'b0, 1'b1, 3'b001, 32'h00000012, 32'h0, 0, 2, 0, 1'b1, 32'h7FFF8001);

        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(2, 0);
            rop = 3'($urandom_range(7, 0));
            run_access(kind != 1, kind != 0, rop, $urandom, $urandom,
                       $urandom_range(3, 0), $urandom_range(3, 1), $urandom_range(2, 0),
                       1'($urandom_range(1, 0)), $urandom);
        end

        // Timeout: rdata primed nonzero, then no response ever arrives
        run_access(1'b0, 1'b1, 3'b010, 32'h00000400, 32'h0, 0, 1, 0, 1'b0, 32'h12345678);
        mem_to_reg_mem = 1'b1; mem_op_mem = 3'b010; mem_addr_mem = 32'h00000500;
        for (int c = 0; c <= 8; c++) begin
            bus_gnt = (c == 0);
            bus_rvalid = 1'b0;
            #1;
            check("to_stall", 32'(lsu_stall), 32'd1);
            check("to_berr_lo", 32'(bus_err), 32'd0);
            step();
        end
        bus_gnt = 1'b0;
        check("to_berr", 32'(bus_err), 32'd1);
        check("to_rdata", mem_rdata_mem, 32'h0);
        check("to_done_stall", 32'(lsu_stall), 32'd0);
        bus_rvalid = 1'b1; bus_rdata = 32'hFFFFFFFF;
        step();
        check("to_pulse_end", 32'(bus_err), 32'd0);
        check("to_late_rdata", mem_rdata_mem, 32'h0);
        bus_rvalid = 1'b0;
        advance = 1'b1;
        step();
        advance = 1'b0; mem_to_reg_mem = 1'b0;
        exp_rdata = 32'h0;
        step();

        // Reset while waiting for a response
        run_access(1'b0, 1'b1, 3'b010, 32'h00000600, 32'h0, 0, 1, 0, 1'b0, 32'hCAFEF00D);
        mem_to_reg_mem = 1'b1; mem_op_mem = 3'b010; mem_addr_mem = 32'h00000700;
        bus_gnt = 1'b1;
        step();
        bus_gnt = 1'b0;
        check("wr_stall", 32'(lsu_stall), 32'd1);
        reset = 1'b1;
        #1;
        check("arst_req", 32'(bus_req), 32'd0);
        check("arst_stall", 32'(lsu_stall), 32'd0);
        check("arst_rdata", mem_rdata_mem, 32'h0);
        mem_to_reg_mem = 1'b0;
        #2;
        reset = 1'b0;
        step();
        check("post_rst_stall", 32'(lsu_stall), 32'd0);
        check("post_rst_req", 32'(bus_req), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
